// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter register stage.
// Holds the FSM state encoding, next-PC select codes and the alignment helper.
package pc_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_BR   = 2'd1,
        SEL_JALR = 2'd2,
        SEL_HOLD = 2'd3
    } pc_sel_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

    // A fetch address must be word aligned; only the two low bits matter.
    function automatic logic word_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: stall > JALR > branch > sequential.
// Reports the chosen source and whether a redirect target is misaligned.
module pc_next_sel
    import pc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        jalr_en,
    input  logic [31:0] jalr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc_s,
    output pc_sel_e     sel_s,
    output logic        misalign_s
);

    // Priority selection of the candidate PC; JALR drops bit 0 of its target.
    always_comb begin
        next_pc_s = pc_plus4;
        sel_s     = SEL_SEQ;
        if (stall) begin
            next_pc_s = pc;
            sel_s     = SEL_HOLD;
        end else if (jalr_en) begin
            next_pc_s = jalr_target & 32'hFFFF_FFFE;
            sel_s     = SEL_JALR;
        end else if (branch_taken) begin
            next_pc_s = branch_target;
            sel_s     = SEL_BR;
        end else begin
            next_pc_s = pc_plus4;
            sel_s     = SEL_SEQ;
        end
    end

    // Only redirect targets are checked; the sequential path is trusted.
    always_comb begin
        misalign_s = 1'b0;
        case (sel_s)
            SEL_BR, SEL_JALR: misalign_s = word_misaligned(next_pc_s[1:0]);
            default:          misalign_s = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_reg_unit.sv
// Architectural PC register with post-reset hold window, stall support and
// a misaligned-target trap state; all outputs come straight from flops.
module pc_reg_unit
    import pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR      = DEF_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR       = DEF_TRAP_VECTOR,
    parameter int          RESET_HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jalr_en,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    input  logic        trap_clr,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        misalign_trap,
    output logic [31:0] trap_pc
);

    localparam int CW = (RESET_HOLD_CYCLES > 0) ? $clog2(RESET_HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD_CYCLES);

    pc_state_e   state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [31:0] pc_r, pc_s;
    logic        pc_valid_r, pc_valid_s;
    logic        trap_r, trap_s;
    logic [31:0] trap_pc_r, trap_pc_s;

    logic [31:0] cand_s;
    pc_sel_e     sel_s;
    logic        misalign_s;

    pc_next_sel u_next_sel (
        .pc            (pc_r),
        .pc_plus4      (pc_plus4),
        .stall         (stall),
        .jalr_en       (jalr_en),
        .jalr_target   (jalr_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc_s     (cand_s),
        .sel_s         (sel_s),
        .misalign_s    (misalign_s)
    );

    // Next-state and next-output logic for the HOLD/RUN/TRAP controller.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        pc_s       = pc_r;
        pc_valid_s = pc_valid_r;
        trap_s     = trap_r;
        trap_pc_s  = trap_pc_r;
        case (state_r)
            HOLD: begin
                pc_valid_s = 1'b0;
                if (cnt_r == HOLD_LAST) begin
                    state_s    = RUN;
                    pc_valid_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CW'(1'b1);
                end
            end
            RUN: begin
                if (sel_s == SEL_HOLD) begin
                    pc_s = pc_r;
                end else if (misalign_s) begin
                    // The offending target is captured but never becomes pc.
                    state_s    = TRAP;
                    pc_s       = TRAP_VECTOR;
                    trap_pc_s  = cand_s;
                    trap_s     = 1'b1;
                    pc_valid_s = 1'b0;
                end else begin
                    pc_s = cand_s;
                end
            end
            TRAP: begin
                pc_s = TRAP_VECTOR;
                if (trap_clr) begin
                    state_s    = RUN;
                    pc_valid_s = 1'b1;
                    trap_s     = 1'b0;
                end else begin
                    pc_valid_s = 1'b0;
                    trap_s     = 1'b1;
                end
            end
            default: begin
                state_s    = HOLD;
                cnt_s      = '0;
                pc_s       = RESET_VECTOR;
                pc_valid_s = 1'b0;
                trap_s     = 1'b0;
                trap_pc_s  = 32'h0000_0000;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= HOLD;
            cnt_r      <= '0;
            pc_r       <= RESET_VECTOR;
            pc_valid_r <= 1'b0;
            trap_r     <= 1'b0;
            trap_pc_r  <= 32'h0000_0000;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            pc_r       <= pc_s;
            pc_valid_r <= pc_valid_s;
            trap_r     <= trap_s;
            trap_pc_r  <= trap_pc_s;
        end
    end

    assign pc            = pc_r;
    assign pc_valid      = pc_valid_r;
    assign misalign_trap = trap_r;
    assign trap_pc       = trap_pc_r;

endmodule
